// File: rtl/output_stream_buffer_if.sv
// ----------------------------------------------------------------------------
// output_stream_buffer_if
// Groups the CPU write port, the downstream valid/ready stream and the status
// flags of output_stream_buffer into one bundle.
//   slave  : the buffer itself (takes writes, drives the stream and status)
//   master : the surroundings (CPU write-back side and output consumer)
// Signals:
//   wr_en, wr_chan, wr_data, hlt   CPU -> buffer
//   full                           buffer -> CPU (stall)
//   out_valid, out_data, out_chan  buffer -> consumer
//   out_ready                      consumer -> buffer
//   count, overflow, drained       buffer status
// ----------------------------------------------------------------------------
interface output_stream_buffer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CHAN_W = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [CHAN_W-1:0] wr_chan;
    logic [DATA_W-1:0] wr_data;
    logic              hlt;
    logic              full;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHAN_W-1:0] out_chan;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              drained;

    modport slave (
        input  wr_en, wr_chan, wr_data, hlt, out_ready,
        output full, out_valid, out_data, out_chan, count, overflow, drained
    );

    modport master (
        output wr_en, wr_chan, wr_data, hlt, out_ready,
        input  full, out_valid, out_data, out_chan, count, overflow, drained
    );
endinterface

// File: rtl/output_stream_buffer.sv
// ----------------------------------------------------------------------------
// output_stream_buffer
// Buffers words written by the CPU (OUT instruction) in a channel-tagged FIFO
// and drains them over a first-word-fall-through valid/ready stream.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high; discards all stored words
//   bus    output_stream_buffer_if.slave (write port, stream, status flags)
// Status: full, out_valid, count, overflow (sticky dropped write) and drained
// (halted and empty) are decoded from registered state only, so there is no
// combinational path from wr_en/out_ready to them.
// ----------------------------------------------------------------------------
module output_stream_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CHAN_W = 2
) (
    input logic                   clk,
    input logic                   reset,
    output_stream_buffer_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = CHAN_W + DATA_W;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_halted;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_MAX);
    assign w_pop   = ~w_empty & bus.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_push  = bus.wr_en & ~r_halted & (~w_full | w_pop);
    // Writes while halted are ignored silently, not counted as overflow.
    assign w_drop  = bus.wr_en & ~r_halted & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.wr_chan, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Latched from registered state above, so a write in the first
            // hlt cycle is still accepted.
            if (bus.hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.full      = w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign bus.out_chan  = w_empty ? '0 : w_head[ENTRY_W-1:DATA_W];
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.drained   = r_halted & w_empty;
endmodule
